// File: rtl/shift_cmd_sequencer_if.sv
// Command channel into the shift sequencer.
// Handshake: a command {cmd_op, cmd_amt} transfers on a rising clock edge
// where cmd_valid && cmd_ready are both high. The master holds cmd_valid,
// cmd_op and cmd_amt stable until that edge. cmd_ready does not depend on
// cmd_valid in the same cycle.
interface shift_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_amt;

  modport master (output cmd_valid, output cmd_op, output cmd_amt, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_amt, output cmd_ready);
endinterface

// File: rtl/shift_cmd_sequencer.sv
// Shift command front-end: buffers {op, amt} commands in a FIFO and replays
// each one to the 8-bit shifter as a per-cycle sel code for amt cycles, or as
// a one-cycle preset / no-op step. Exactly one IDLE cycle separates commands.
module shift_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  shift_cmd_sequencer_if.slave        cmd,
  output logic [2:0]                  sel,
  output logic                        sh_reset,
  output logic                        done,
  output logic                        busy,
  output logic [CW-1:0]               fifo_count,
  output logic [1:0]                  state_o
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_INIT = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ONE  = 2'd2
  } state_t;

  state_t        state_q;
  logic [2:0]    sel_q;
  logic          sh_reset_q;
  logic          done_q;
  logic [2:0]    cnt_q;

  logic [5:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  logic          push;
  logic          pop;
  logic [2:0]    head_op;
  logic [2:0]    head_amt;

  // Ready comes only from the registered count, so a full FIFO refuses a
  // command even in a cycle where it pops.
  assign cmd.cmd_ready = (count_q != CW'(DEPTH));
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign pop           = (state_q == IDLE) && (count_q != '0);
  assign head_op       = mem_q[rd_ptr_q][5:3];
  assign head_amt      = mem_q[rd_ptr_q][2:0];

  assign sel        = sel_q;
  assign sh_reset   = sh_reset_q;
  assign done       = done_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign state_o    = state_q;

  // FIFO storage; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd.cmd_op, cmd.cmd_amt};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Replay FSM with registered sel / sh_reset / done.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      sel_q      <= 3'd0;
      sh_reset_q <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          sel_q      <= 3'd0;
          sh_reset_q <= 1'b0;
          done_q     <= 1'b0;
          if (pop) begin
            if (head_op != OP_NOP && head_op != OP_INIT && head_amt != 3'd0) begin
              state_q <= RUN;
              sel_q   <= head_op;
              cnt_q   <= head_amt;
              // A single-cycle run is its own last cycle.
              done_q  <= (head_amt == 3'd1);
            end else begin
              state_q    <= ONE;
              done_q     <= 1'b1;
              sh_reset_q <= (head_op == OP_INIT);
            end
          end
        end
        RUN: begin
          if (cnt_q == 3'd1) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            done_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q - 3'd1;
            done_q <= (cnt_q == 3'd2);
          end
        end
        ONE: begin
          state_q    <= IDLE;
          sh_reset_q <= 1'b0;
          done_q     <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          sel_q      <= 3'd0;
          sh_reset_q <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Bench for shift_cmd_sequencer: a per-cycle vector table for the basic
// command types, then hand-written sequences for FIFO fill, mid-run reset
// and push-during-last-pop. A small shifter model turns sel/sh_reset into
// the 8-bit value the real shifter would hold.
module tb_shift_cmd_sequencer;

  logic       clk;
  logic       reset;
  logic [2:0] sel;
  logic       sh_reset;
  logic       done;
  logic       busy;
  logic [2:0] fifo_count;
  logic [1:0] state_o;

  shift_cmd_sequencer_if cmd_if();

  shift_cmd_sequencer #(.DEPTH(4), .CW(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd_if),
    .sel        (sel),
    .sh_reset   (sh_reset),
    .done       (done),
    .busy       (busy),
    .fifo_count (fifo_count),
    .state_o    (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // shifter model
  logic [7:0] shv;
  always @(posedge clk) begin
    if (!reset) shv <= 8'h00;
    else if (sh_reset) shv <= 8'hAF;
    else begin
      case (sel)
        3'd1, 3'd3: shv <= {shv[6:0], 1'b0};
        3'd2:       shv <= {1'b0, shv[7:1]};
        3'd4:       shv <= {shv[7], shv[7:1]};
        3'd5:       shv <= {shv[6:0], shv[7]};
        3'd6:       shv <= {shv[0], shv[7:1]};
        default:    shv <= shv;
      endcase
    end
  end

  // scoreboard
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int v, input int op, input int amt);
    cmd_if.cmd_valid = (v != 0);
    cmd_if.cmd_op    = 3'(op);
    cmd_if.cmd_amt   = 3'(amt);
  endtask

  // vector table: inputs before an edge, outputs expected just after it
  typedef struct {
    int v, op, amt;
    int sel, shr, done, cnt, rdy, busy, shv;
  } vec_t;

  function automatic vec_t mk(int v, int op, int amt, int s, int shr, int d,
                              int cnt, int rdy, int b, int sh);
    vec_t r;
    r.v = v; r.op = op; r.amt = amt; r.sel = s; r.shr = shr; r.done = d;
    r.cnt = cnt; r.rdy = rdy; r.busy = b; r.shv = sh;
    return r;
  endfunction

  vec_t tbl [29];

  // FIFO-fill monitor state
  logic [5:0] exp_q [$];
  logic       mon_en = 1'b0;
  int         prev_cnt, max_cnt, run_len, n_done;
  logic [2:0] run_op;

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      chk("t4 count step", int'(int'(fifo_count) >= prev_cnt - 1), 1);
      if (fifo_count == 3'd4) chk("t4 ready when full", int'(cmd_if.cmd_ready), 0);
      prev_cnt = int'(fifo_count);
      if (sel != 3'd0) begin
        if (run_len == 0) run_op = sel;
        else chk("t4 sel stable", int'(sel), int'(run_op));
        run_len++;
        if (done) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL t4 extra command: got op %0d len %0d required none", run_op, run_len);
          end else begin
            chk("t4 cmd order", int'({run_op, 3'(run_len)}), int'(exp_q.pop_front()));
            n_done++;
          end
          run_len = 0;
        end
      end
    end
  end

  logic [5:0] t4_cmds [7];
  logic       acc;
  int         idx;
  bit         t4_end;

  initial begin
    // test 1: init then sll x3
    tbl[0]  = mk(1, 7, 0,  0, 0, 0, 1, 1, 1, 'h00);
    tbl[1]  = mk(1, 1, 3,  0, 1, 1, 1, 1, 1, 'h00);
    tbl[2]  = mk(0, 0, 0,  0, 0, 0, 1, 1, 1, 'hAF);
    tbl[3]  = mk(0, 0, 0,  1, 0, 0, 0, 1, 1, 'hAF);
    tbl[4]  = mk(0, 0, 0,  1, 0, 0, 0, 1, 1, 'h5E);
    tbl[5]  = mk(0, 0, 0,  1, 0, 1, 0, 1, 1, 'hBC);
    tbl[6]  = mk(0, 0, 0,  0, 0, 0, 0, 1, 0, 'h78);
    // test 2a: init then rol x4
    tbl[7]  = mk(1, 7, 0,  0, 0, 0, 1, 1, 1, 'h78);
    tbl[8]  = mk(1, 5, 4,  0, 1, 1, 1, 1, 1, 'h78);
    tbl[9]  = mk(0, 0, 0,  0, 0, 0, 1, 1, 1, 'hAF);
    tbl[10] = mk(0, 0, 0,  5, 0, 0, 0, 1, 1, 'hAF);
    tbl[11] = mk(0, 0, 0,  5, 0, 0, 0, 1, 1, 'h5F);
    tbl[12] = mk(0, 0, 0,  5, 0, 0, 0, 1, 1, 'hBE);
    tbl[13] = mk(0, 0, 0,  5, 0, 1, 0, 1, 1, 'h7D);
    tbl[14] = mk(0, 0, 0,  0, 0, 0, 0, 1, 0, 'hFA);
    // test 2b: init then sra x2
    tbl[15] = mk(1, 7, 0,  0, 0, 0, 1, 1, 1, 'hFA);
    tbl[16] = mk(1, 4, 2,  0, 1, 1, 1, 1, 1, 'hFA);
    tbl[17] = mk(0, 0, 0,  0, 0, 0, 1, 1, 1, 'hAF);
    tbl[18] = mk(0, 0, 0,  4, 0, 0, 0, 1, 1, 'hAF);
    tbl[19] = mk(0, 0, 0,  4, 0, 1, 0, 1, 1, 'hD7);
    tbl[20] = mk(0, 0, 0,  0, 0, 0, 0, 1, 0, 'hEB);
    // test 3: nop with amt, shift with amt 0
    tbl[21] = mk(1, 0, 5,  0, 0, 0, 1, 1, 1, 'hEB);
    tbl[22] = mk(1, 2, 0,  0, 0, 1, 1, 1, 1, 'hEB);
    tbl[23] = mk(0, 0, 0,  0, 0, 0, 1, 1, 1, 'hEB);
    tbl[24] = mk(0, 0, 0,  0, 0, 1, 0, 1, 1, 'hEB);
    tbl[25] = mk(0, 0, 0,  0, 0, 0, 0, 1, 0, 'hEB);
    // single-cycle sla
    tbl[26] = mk(1, 3, 1,  0, 0, 0, 1, 1, 1, 'hEB);
    tbl[27] = mk(0, 0, 0,  3, 0, 1, 0, 1, 1, 'hEB);
    tbl[28] = mk(0, 0, 0,  0, 0, 0, 0, 1, 0, 'hD6);

    t4_cmds[0] = {3'd6, 3'd7};
    t4_cmds[1] = {3'd1, 3'd2};
    t4_cmds[2] = {3'd2, 3'd3};
    t4_cmds[3] = {3'd3, 3'd1};
    t4_cmds[4] = {3'd4, 3'd2};
    t4_cmds[5] = {3'd5, 3'd3};
    t4_cmds[6] = {3'd6, 3'd1};

    // reset state
    reset = 1'b0;
    drive(0, 0, 0);
    cyc(); cyc();
    chk("rst sel",   int'(sel), 0);
    chk("rst shr",   int'(sh_reset), 0);
    chk("rst done",  int'(done), 0);
    chk("rst count", int'(fifo_count), 0);
    chk("rst ready", int'(cmd_if.cmd_ready), 1);
    chk("rst busy",  int'(busy), 0);
    chk("rst state", int'(state_o), 0);
    reset = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].amt);
      cyc();
      chk($sformatf("r%0d sel", i),   int'(sel),              tbl[i].sel);
      chk($sformatf("r%0d shr", i),   int'(sh_reset),         tbl[i].shr);
      chk($sformatf("r%0d done", i),  int'(done),             tbl[i].done);
      chk($sformatf("r%0d count", i), int'(fifo_count),       tbl[i].cnt);
      chk($sformatf("r%0d ready", i), int'(cmd_if.cmd_ready), tbl[i].rdy);
      chk($sformatf("r%0d busy", i),  int'(busy),             tbl[i].busy);
      chk($sformatf("r%0d shv", i),   int'(shv),              tbl[i].shv);
    end
    drive(0, 0, 0);

    // test 4: fill the FIFO while a long ror runs
    prev_cnt = 0; max_cnt = 0; run_len = 0; n_done = 0; idx = 0;
    t4_end = 1'b0;
    mon_en = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (idx == 7 && exp_q.size() == 0 && !busy) begin
        t4_end = 1'b1;
        break;
      end
      if (idx < 7) drive(1, int'(t4_cmds[idx][5:3]), int'(t4_cmds[idx][2:0]));
      else drive(0, 0, 0);
      @(negedge clk);
      acc = cmd_if.cmd_valid && cmd_if.cmd_ready;
      if (acc) begin
        exp_q.push_back(t4_cmds[idx]);
        idx++;
      end
      cyc();
    end
    drive(0, 0, 0);
    cyc();
    mon_en = 1'b0;
    chk("t4 finished in budget", int'(t4_end), 1);
    chk("t4 commands completed", n_done, 7);
    chk("t4 peak count", max_cnt, 4);

    // test 5: reset in the 3rd cycle of a 7-cycle sll, with one queued
    drive(1, 1, 7);
    cyc();
    drive(1, 2, 3);
    cyc();
    drive(0, 0, 0);
    chk("t5 run sel", int'(sel), 1);
    chk("t5 run count", int'(fifo_count), 1);
    cyc();
    chk("t5 c2 done", int'(done), 0);
    cyc();
    chk("t5 c3 done", int'(done), 0);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("t5 sel",   int'(sel), 0);
    chk("t5 done",  int'(done), 0);
    chk("t5 count", int'(fifo_count), 0);
    chk("t5 ready", int'(cmd_if.cmd_ready), 1);
    chk("t5 busy",  int'(busy), 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("t5 post%0d done", k), int'(done), 0);
      chk($sformatf("t5 post%0d sel", k),  int'(sel), 0);
      chk($sformatf("t5 post%0d busy", k), int'(busy), 0);
    end

    // test 6: push while the last entry pops
    drive(1, 2, 2);
    cyc();
    chk("t6 e0 count", int'(fifo_count), 1);
    drive(1, 5, 1);
    cyc();
    drive(0, 0, 0);
    chk("t6 e1 count", int'(fifo_count), 1);
    chk("t6 e1 sel",   int'(sel), 2);
    cyc();
    chk("t6 e2 sel",   int'(sel), 2);
    chk("t6 e2 done",  int'(done), 1);
    cyc();
    chk("t6 gap sel",  int'(sel), 0);
    chk("t6 gap done", int'(done), 0);
    chk("t6 gap busy", int'(busy), 1);
    chk("t6 gap count", int'(fifo_count), 1);
    cyc();
    chk("t6 e4 sel",   int'(sel), 5);
    chk("t6 e4 done",  int'(done), 1);
    chk("t6 e4 count", int'(fifo_count), 0);
    cyc();
    chk("t6 end sel",  int'(sel), 0);
    chk("t6 end busy", int'(busy), 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shift_cmd_sequencer.md
Name: shift_cmd_sequencer

Overview:
Command front-end for the 8-bit shifter stage. It accepts shift commands (opcode and count) over a valid/ready handshake and buffers them in a small FIFO. It replays each command to the shifter as a per-cycle sel code for the requested number of cycles, or as a one-cycle shifter preset. It reports per-command completion and overall busy status to the controller above it.

Parameters:
DEPTH, 4, command FIFO depth (power of two, ≥2)
CW, 3, FIFO occupancy counter width (log2(DEPTH)+1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-low reset (0 = reset, sampled on posedge clk)
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept a command
cmd_op  input  3  0 = nop, 1 = sll, 2 = srl, 3 = sla, 4 = sra, 5 = rol, 6 = ror, 7 = init (shifter preset)
cmd_amt  input  3  repeat count 0..7 (ignored for op 0/7)
sel  output  3  shifter opcode, registered
sh_reset  output  1  shifter preset strobe (active-high), registered
done  output  1  one-cycle pulse in the last output cycle of each command
busy  output  1  FIFO non-empty or FSM not IDLE
fifo_count  output  CW  current FIFO occupancy

Behaviour:
- Reset (reset == 0 at posedge): FIFO flushed; fifo_count = 0; state = IDLE; sel = 0; sh_reset = 0; done = 0. Consequently cmd_ready = 1 and busy = 0. Reset wins over every other event, including mid-command: the in-flight command is dropped, not completed, and no done pulse is issued.
- cmd_ready = (fifo_count != DEPTH), combinational from the registered count.
- Push on posedge when cmd_valid && cmd_ready. The entry stores {op, amt}.
- Pop only in IDLE with fifo_count != 0.
- Simultaneous push and pop leaves the count unchanged.
- When full, cmd_ready = 0 even if a pop occurs in the same cycle (no pass-through).
- FIFO ordering is strict first-in, first-out. Pointers wrap modulo DEPTH.
- FSM states: IDLE, RUN, ONE.
- IDLE: sel = 0, sh_reset = 0, done = 0. On a pop, branch on the popped command:
  - op in 1..6 and amt != 0: go to RUN; sel <= op; cnt <= amt.
  - op == 7: go to ONE; sh_reset <= 1; done <= 1; sel <= 0.
  - op == 0 or amt == 0: go to ONE; done <= 1; sel <= 0.
- RUN: sel holds op for exactly amt consecutive cycles. done = 1 in the last of those cycles (cnt == 1). Next state is IDLE with sel <= 0.
- ONE: lasts exactly one cycle. Next state is IDLE; sh_reset and done return to 0.
- Latency: a command accepted at edge E0 is popped at E1. Its outputs are visible from E1 to E(1+amt), so the shifter samples it at edges E2..E(amt+1).
- Back-to-back commands are separated by exactly one IDLE cycle with sel = 0. The shifter therefore holds its value between commands.
- busy = (state != IDLE) || (fifo_count != 0).
- Opcodes are passed through unmodified. sla (3) produces the same shifter result as sll (1).

Test Plan:
1. Reset, then push init followed by {op1, amt3} → sh_reset high 1 cycle with done, one idle cycle, then sel = 1 for 3 cycles with done on the 3rd. Shifter output goes 0xAF → 0x5E → 0xBC → 0x78.
2. Push init followed by {op5, amt4} (rol) → sel = 5 for 4 cycles, final shifter output 0xFA. Push init followed by {op4, amt2} (sra) → 0xAF → 0xD7 → 0xEB.
3. Push {op0, amt5} and {op2, amt0} → each gives one cycle with sel = 0 and done = 1. Shifter output is unchanged.
4. Push {op6, amt7} and then hold cmd_valid for 6 more commands → fifo_count reaches 4 and cmd_ready drops. After the first command completes, exactly one slot frees per pop. All commands execute in push order with no loss or duplication.
5. Assert reset = 0 in the 3rd cycle of a {op1, amt7} RUN → the next cycle shows sel = 0, done = 0, fifo_count = 0, cmd_ready = 1, busy = 0. No done pulse is issued for the aborted command.
6. Push a command in the same cycle the FSM pops the last FIFO entry → fifo_count stays at 1. The new command starts after the current one, with a one-cycle gap.
